// File: rtl/dma_pkg.sv
// Shared AHB-Lite encodings and DMA controller state type.
package dma_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FINISH
  } dma_state_t;

endpackage

// File: rtl/dma_fifo.sv
// Chunk buffer between the read and write bursts: synchronous FIFO with flush
// and a registered occupancy count.
module dma_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: storage has no reset; occupancy is tracked by count, so stale words are never observed.
  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ahb_dma_master.sv
// AHB-Lite block-copy master: read burst fills a FIFO chunk, write burst drains it.
// Optional macro DMA_ECC_ABORT_EN: an ECC error on a read beat aborts the copy.
module ahb_dma_master
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  ecc_error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_t            state;
  htrans_t               htrans_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [LEN_WIDTH-1:0]  remaining, rem_next;
  logic [CNT_W-1:0]      chunk, next_chunk, addr_left, data_left;
  logic                  data_phase;
  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
`ifdef DMA_ECC_ABORT_EN
  logic                  abort_q;
`endif

  function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_WIDTH-1:0] n);
    return (n >= LEN_WIDTH'(FIFO_DEPTH)) ? CNT_W'(FIFO_DEPTH) : n[CNT_W-1:0];
  endfunction

  assign rem_next   = remaining - LEN_WIDTH'(chunk);
  assign next_chunk = chunk_of(rem_next);

  assign fifo_push  = (state == ST_READ)  && data_phase && HREADY;
  assign fifo_pop   = (state == ST_WRITE) && data_phase && HREADY;
  assign fifo_flush = (state == ST_FINISH);

  dma_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .push   (fifo_push && !fifo_full),
    .pop    (fifo_pop && !fifo_empty),
    .flush  (fifo_flush),
    .wdata  (HRDATA),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign HTRANS = htrans_q;
  assign HBURST = (htrans_q == HTRANS_IDLE) ? HBURST_SINGLE : HBURST_INCR;
  assign HSIZE  = HSIZE_WORD;
  // Head only advances on a completed data phase, so HWDATA holds through wait states.
  assign HWDATA = ((state == ST_WRITE) && data_phase) ? fifo_head : '0;

  // NOTE: every state register uses <= so all updates see pre-edge values, like the hardware.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      htrans_q   <= HTRANS_IDLE;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      remaining  <= '0;
      chunk      <= '0;
      addr_left  <= '0;
      data_left  <= '0;
      data_phase <= 1'b0;
`ifdef DMA_ECC_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            err       <= 1'b0;
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            remaining <= len;
            chunk     <= chunk_of(len);
            addr_left <= chunk_of(len);
            data_left <= chunk_of(len);
            if (len == '0) begin
              state <= ST_FINISH;
            end else begin
              state    <= ST_READ;
              htrans_q <= HTRANS_NONSEQ;
              HADDR    <= src_addr;
              HWRITE   <= 1'b0;
            end
          end
        end

        ST_READ, ST_WRITE: begin
          if (HREADY) begin
            data_phase <= (htrans_q != HTRANS_IDLE);
            if (htrans_q != HTRANS_IDLE) begin
              addr_left <= addr_left - CNT_W'(1);
              if (addr_left > CNT_W'(1)) begin
                htrans_q <= HTRANS_SEQ;
                HADDR    <= HADDR + ADDR_WIDTH'(1);
              end else begin
                htrans_q <= HTRANS_IDLE;
              end
            end
            if (data_phase) begin
              data_left <= data_left - CNT_W'(1);
              if (state == ST_READ && ecc_error) err <= 1'b1;
              if (data_left == CNT_W'(1)) begin
                if (state == ST_READ) begin
                  state     <= ST_WRITE;
                  htrans_q  <= HTRANS_NONSEQ;
                  HWRITE    <= 1'b1;
                  HADDR     <= dst_q;
                  addr_left <= chunk;
                  data_left <= chunk;
                end else begin
                  src_q     <= src_q + ADDR_WIDTH'(chunk);
                  dst_q     <= dst_q + ADDR_WIDTH'(chunk);
                  remaining <= rem_next;
                  HWRITE    <= 1'b0;
                  if (rem_next == '0) begin
                    state <= ST_FINISH;
                  end else begin
                    state     <= ST_READ;
                    htrans_q  <= HTRANS_NONSEQ;
                    HADDR     <= src_q + ADDR_WIDTH'(chunk);
                    chunk     <= next_chunk;
                    addr_left <= next_chunk;
                    data_left <= next_chunk;
                  end
                end
              end
            end
`ifdef DMA_ECC_ABORT_EN
            // Stop issuing addresses; finish once no read data phase is outstanding.
            if (state == ST_READ && data_phase && (ecc_error || abort_q)) begin
              htrans_q <= HTRANS_IDLE;
              if (htrans_q == HTRANS_IDLE) begin
                state      <= ST_FINISH;
                data_phase <= 1'b0;
                HWRITE     <= 1'b0;
                abort_q    <= 1'b0;
              end else begin
                abort_q <= 1'b1;
              end
            end
`endif
          end
        end

        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Directed bench for ahb_dma_master with a behavioural word SRAM slave and a write scoreboard.
module tb_ahb_dma_master;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  src_addr = '0, dst_addr = '0;
  logic [10:0] len = '0;
  logic        busy, done, err;
  logic [9:0]  HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY;
  logic        ecc_error;

  logic [31:0] mem [1024];
  logic        dp_valid, dp_write;
  logic [9:0]  dp_addr;
  int          ws_left, beat, rd_beat;
  bit          wait_mode = 1'b0, ecc_en = 1'b0, stab_en = 1'b0;
  int          ecc_beat = 0;
  wr_t         wr_log[$], exp_q[$];
  logic [9:0]  rd_log[$], rd_exp[$];
  int          n_checks = 0, n_fail = 0;

  logic        prev_hready = 1'b1;
  logic [9:0]  prev_haddr = '0;
  logic [1:0]  prev_htrans = '0;
  logic [31:0] prev_hwdata = '0;

  ahb_dma_master dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HTRANS   (HTRANS),
    .HBURST   (HBURST),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .ecc_error(ecc_error)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM slave: reads return mem[], completed writes are logged for the scoreboard.
  assign HRDATA    = (dp_valid && !dp_write) ? mem[dp_addr] : '0;
  assign ecc_error = ecc_en && dp_valid && !dp_write && (rd_beat == ecc_beat);

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      HREADY   <= 1'b1;
      ws_left  <= 0;
      beat     <= 0;
      rd_beat  <= 0;
    end else if (HREADY) begin
      if (dp_valid && dp_write) wr_log.push_back(wr_t'{dp_addr, HWDATA});
      if (dp_valid && !dp_write) begin
        rd_log.push_back(dp_addr);
        rd_beat <= rd_beat + 1;
      end
      dp_valid <= HTRANS[1];
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
      if (HTRANS[1]) begin
        beat <= beat + 1;
        if (wait_mode && beat[0]) begin
          HREADY  <= 1'b0;
          ws_left <= 1;
        end
      end
    end else if (ws_left == 0) begin
      HREADY <= 1'b1;
    end else begin
      ws_left <= ws_left - 1;
    end
  end

  // Any cycle following a wait cycle must present the same address-phase and write data.
  always @(negedge HCLK) begin
    if (stab_en && !prev_hready) begin
      check("stall_haddr", 64'(HADDR), 64'(prev_haddr));
      check("stall_htrans", 64'(HTRANS), 64'(prev_htrans));
      check("stall_hwdata", 64'(HWDATA), 64'(prev_hwdata));
    end
    prev_hready = HREADY;
    prev_haddr  = HADDR;
    prev_htrans = HTRANS;
    prev_hwdata = HWDATA;
  end

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    wr_log.delete();
    rd_log.delete();
    HRESETn = 1'b1;
  endtask

  task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                          input bit expect_writes, output int cycles);
    wr_t e, a;
    exp_q.delete();
    wr_log.delete();
    rd_log.delete();
    if (expect_writes)
      for (int i = 0; i < int'(n); i++) exp_q.push_back(wr_t'{d + 10'(i), mem[s + 10'(i)]});
    @(negedge HCLK);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(posedge HCLK);
    #1 start = 1'b0;
    cycles = 1;
    while (!done && cycles < 2000) begin
      @(posedge HCLK);
      #1 cycles++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("wr_count", 64'(wr_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_log.pop_front();
      check("wr_beat", 64'(a), 64'(e));
    end
    @(posedge HCLK);
    #1 check("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    for (int i = 0; i < 6; i++) mem[i] = 32'hA0 + i;

    // Reset values
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_haddr", 64'(HADDR), 64'd0);
    check("rst_hburst", 64'(HBURST), 64'd0);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    check("hsize_word", 64'(HSIZE), 64'd2);
    do_reset();

    // 6-word copy, zero wait states: chunks of 4 and 2
    run_copy(10'h000, 10'h100, 11'd6, 1'b1, cyc);
    check("lat_6w_nowait", 64'(cyc), 64'd18);
    check("err_clean", 64'(err), 64'd0);

    // Same copy with 2 wait states on every other beat (6 stalled beats)
    do_reset();
    wait_mode = 1'b1;
    stab_en   = 1'b1;
    run_copy(10'h000, 10'h100, 11'd6, 1'b1, cyc);
    check("lat_6w_wait", 64'(cyc), 64'd30);
    wait_mode = 1'b0;
    stab_en   = 1'b0;

    // Zero-length copy: no bus activity
    do_reset();
    run_copy(10'h020, 10'h300, 11'd0, 1'b1, cyc);
    check("lat_len0", 64'(cyc), 64'd2);
    check("len0_no_beats", 64'(beat), 64'd0);

    // Address wrap on the source side
    do_reset();
    rd_exp.delete();
    rd_exp.push_back(10'h3FE);
    rd_exp.push_back(10'h3FF);
    rd_exp.push_back(10'h000);
    rd_exp.push_back(10'h001);
    run_copy(10'h3FE, 10'h200, 11'd4, 1'b1, cyc);
    check("wrap_rd_count", 64'(rd_log.size()), 64'd4);
    while (rd_exp.size() > 0 && rd_log.size() > 0)
      check("wrap_rd_addr", 64'(rd_log.pop_front()), 64'(rd_exp.pop_front()));

    // ECC error on read beat 2 of an 8-word copy
    do_reset();
    ecc_en   = 1'b1;
    ecc_beat = 2;
`ifdef DMA_ECC_ABORT_EN
    run_copy(10'h010, 10'h140, 11'd8, 1'b0, cyc);
`else
    run_copy(10'h010, 10'h140, 11'd8, 1'b1, cyc);
`endif
    ecc_en = 1'b0;
    check("ecc_err_sticky", 64'(err), 64'd1);

    // Reset asserted during a write burst, then a clean copy
    do_reset();
    @(negedge HCLK);
    start = 1'b1; src_addr = 10'h000; dst_addr = 10'h180; len = 11'd6;
    @(posedge HCLK);
    #1 start = 1'b0;
    cyc = 0;
    while (!(HWRITE && HTRANS[1]) && cyc < 200) begin
      @(posedge HCLK);
      #1 cyc++;
    end
    check("reached_write", 64'(HWRITE && HTRANS[1]), 64'd1);
    HRESETn = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_htrans", 64'(HTRANS), 64'd0);
    check("midrst_hwrite", 64'(HWRITE), 64'd0);
    @(negedge HCLK);
    wr_log.delete();
    rd_log.delete();
    HRESETn = 1'b1;
    run_copy(10'h000, 10'h180, 11'd6, 1'b1, cyc);
    check("lat_after_rst", 64'(cyc), 64'd18);
    check("err_after_rst", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
